attack_map_collect: RTL and testbench

- Sits directly downstream of the 64 per-square attack detectors (one per ROW/COL).
- Gathers their per-square attacked/attacked_valid results for one board into a 64-bit attack map.
- Derives in-check for a given king square and a population count.
- Presents the result to the move-evaluation stage with a valid/ready handshake; also reports duplicate, stray and timeout faults.

---
 rtl/attack_map_collect.sv | 177 +++++++++++++++++
 tb/tb_attack_map_collect.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attack_map_collect.sv
`default_nettype none
// ============================================================================
// Module  : attack_map_collect
// Brief   : Collects 64 per-square attack results into one map, derives
//           in-check and popcount, and hands the result on via valid/ready.
// Rev     : 1.0
// ============================================================================
module attack_map_collect #(
    parameter int TIMEOUT = 64,
    parameter int SQUARES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               board_valid,
    input  logic [5:0]         king_sq,
    input  logic [SQUARES-1:0] attacked,
    input  logic [SQUARES-1:0] attacked_valid,
    output logic [SQUARES-1:0] map,
    output logic               map_valid,
    input  logic               map_ready,
    output logic               in_check,
    output logic [6:0]         attack_count,
    output logic               busy,
    output logic               err_dup,
    output logic               err_stray,
    output logic               err_timeout,
    output logic               err_overrun
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [SQUARES-1:0] map_q, map_d;
    logic [SQUARES-1:0] seen_q, seen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         king_q, king_d;
    logic               map_valid_q, map_valid_d;
    logic               in_check_q, in_check_d;
    logic [6:0]         count_q, count_d;
    logic               busy_q, busy_d;
    logic               dup_q, dup_d;
    logic               stray_q, stray_d;
    logic               tmo_q, tmo_d;
    logic               ovr_q, ovr_d;

    logic [SQUARES-1:0] w_merged_map;
    logic [SQUARES-1:0] w_merged_seen;
    logic               w_complete;
    logic               w_start;

    function automatic logic [6:0] popcount(input logic [SQUARES-1:0] v);
        logic [6:0] sum;
        sum = 7'd0;
        for (int i = 0; i < SQUARES; i++) begin
            sum = sum + {6'd0, v[i]};
        end
        return sum;
    endfunction

    assign w_merged_map  = (map_q & ~attacked_valid) | (attacked & attacked_valid);
    assign w_merged_seen = seen_q | attacked_valid;
    assign w_complete    = &w_merged_seen;
    // A new board is taken in IDLE, mid-collection (restart) or on a HOLD handshake.
    assign w_start = board_valid &&
                     ((state_q == S_IDLE) || (state_q == S_COLLECT) ||
                      ((state_q == S_HOLD) && map_ready));

    always_comb begin
        state_d     = state_q;
        map_d       = map_q;
        seen_d      = seen_q;
        cnt_d       = cnt_q;
        king_d      = king_q;
        map_valid_d = map_valid_q;
        in_check_d  = in_check_q;
        count_d     = count_q;
        dup_d       = dup_q;
        stray_d     = stray_q;
        tmo_d       = tmo_q;
        ovr_d       = ovr_q;

        case (state_q)
            S_IDLE: begin
                if (|attacked_valid) stray_d = 1'b1;
            end
            S_COLLECT: begin
                if (!board_valid) begin
                    if (|(seen_q & attacked_valid)) dup_d = 1'b1;
                    map_d  = w_merged_map;
                    seen_d = w_merged_seen;
                    cnt_d  = cnt_q + 1'b1;
                    // Completion wins over a coincident timeout.
                    if (w_complete) begin
                        state_d     = S_HOLD;
                        map_valid_d = 1'b1;
                        count_d     = popcount(w_merged_map);
                        in_check_d  = w_merged_map[king_q];
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        tmo_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (|attacked_valid) stray_d = 1'b1;
                if (map_ready) begin
                    map_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (board_valid) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_start) begin
            state_d     = S_COLLECT;
            map_d       = '0;
            seen_d      = '0;
            cnt_d       = '0;
            king_d      = king_sq;
            map_valid_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            map_q       <= '0;
            seen_q      <= '0;
            cnt_q       <= '0;
            king_q      <= '0;
            map_valid_q <= 1'b0;
            in_check_q  <= 1'b0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            dup_q       <= 1'b0;
            stray_q     <= 1'b0;
            tmo_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            map_q       <= map_d;
            seen_q      <= seen_d;
            cnt_q       <= cnt_d;
            king_q      <= king_d;
            map_valid_q <= map_valid_d;
            in_check_q  <= in_check_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            dup_q       <= dup_d;
            stray_q     <= stray_d;
            tmo_q       <= tmo_d;
            ovr_q       <= ovr_d;
        end
    end

    assign map          = map_q;
    assign map_valid    = map_valid_q;
    assign in_check     = in_check_q;
    assign attack_count = count_q;
    assign busy         = busy_q;
    assign err_dup      = dup_q;
    assign err_stray    = stray_q;
    assign err_timeout  = tmo_q;
    assign err_overrun  = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_attack_map_collect.sv
`default_nettype none
// ============================================================================
// Module  : tb_attack_map_collect
// Brief   : Directed plus randomized checks of attack_map_collect against a
//           cycle-level behavioural model; two instances (TIMEOUT 64 and 4).
// Rev     : 1.0
// ============================================================================
module tb_attack_map_collect;

    logic        clk = 1'b0;
    logic        reset;
    logic        board_valid;
    logic [5:0]  king_sq;
    logic [63:0] attacked;
    logic [63:0] attacked_valid;
    logic        map_ready;

    logic [63:0] a_map, b_map;
    logic        a_mv, b_mv, a_ic, b_ic, a_busy, b_busy;
    logic [6:0]  a_pc, b_pc;
    logic        a_dup, b_dup, a_str, b_str, a_tmo, b_tmo, a_ovr, b_ovr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    attack_map_collect #(.TIMEOUT(64)) u_dut_a (
        .clk(clk), .reset(reset), .board_valid(board_valid), .king_sq(king_sq),
        .attacked(attacked), .attacked_valid(attacked_valid),
        .map(a_map), .map_valid(a_mv), .map_ready(map_ready), .in_check(a_ic),
        .attack_count(a_pc), .busy(a_busy), .err_dup(a_dup), .err_stray(a_str),
        .err_timeout(a_tmo), .err_overrun(a_ovr)
    );

    attack_map_collect #(.TIMEOUT(4)) u_dut_b (
        .clk(clk), .reset(reset), .board_valid(board_valid), .king_sq(king_sq),
        .attacked(attacked), .attacked_valid(attacked_valid),
        .map(b_map), .map_valid(b_mv), .map_ready(map_ready), .in_check(b_ic),
        .attack_count(b_pc), .busy(b_busy), .err_dup(b_dup), .err_stray(b_str),
        .err_timeout(b_tmo), .err_overrun(b_ovr)
    );

    // Model phase: 0 waiting for a board, 1 gathering, 2 result on offer.
    typedef struct packed {
        logic [1:0]  ph;
        logic [63:0] map;
        logic [63:0] seen;
        logic [7:0]  cyc;
        logic [5:0]  king;
        logic        mv;
        logic        ic;
        logic [6:0]  pc;
        logic        dup, stray, tmo, ovr;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_rst();
        mdl_t z;
        z = '0;
        return z;
    endfunction

    function automatic mdl_t step(mdl_t s, int tmo, logic bv, logic [5:0] k,
                                  logic [63:0] a, logic [63:0] av, logic rdy);
        mdl_t n;
        logic accept;
        n = s;
        accept = 1'b0;
        if (s.ph == 2'd0) begin
            if (av != 64'd0) n.stray = 1'b1;
            accept = bv;
        end else if (s.ph == 2'd1) begin
            if (bv) begin
                accept = 1'b1;
            end else begin
                if ((s.seen & av) != 64'd0) n.dup = 1'b1;
                for (int i = 0; i < 64; i++) begin
                    if (av[i]) n.map[i] = a[i];
                end
                n.seen = s.seen | av;
                n.cyc  = s.cyc + 8'd1;
                if (n.seen == {64{1'b1}}) begin
                    n.ph = 2'd2;
                    n.mv = 1'b1;
                    n.pc = 7'($countones(n.map));
                    n.ic = n.map[s.king];
                end else if (int'(s.cyc) == tmo - 1) begin
                    n.tmo = 1'b1;
                    n.ph  = 2'd0;
                end
            end
        end else begin
            if (av != 64'd0) n.stray = 1'b1;
            if (rdy) begin
                n.mv = 1'b0;
                n.ph = 2'd0;
                accept = bv;
            end else if (bv) begin
                n.ovr = 1'b1;
            end
        end
        if (accept) begin
            n.ph   = 2'd1;
            n.map  = 64'd0;
            n.seen = 64'd0;
            n.cyc  = 8'd0;
            n.king = k;
            n.mv   = 1'b0;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("A.map",   a_map,         ma.map);
        chk("A.mv",    64'(a_mv),     64'(ma.mv));
        chk("A.ic",    64'(a_ic),     64'(ma.ic));
        chk("A.pc",    64'(a_pc),     64'(ma.pc));
        chk("A.busy",  64'(a_busy),   64'(ma.ph != 2'd0));
        chk("A.dup",   64'(a_dup),    64'(ma.dup));
        chk("A.stray", 64'(a_str),    64'(ma.stray));
        chk("A.tmo",   64'(a_tmo),    64'(ma.tmo));
        chk("A.ovr",   64'(a_ovr),    64'(ma.ovr));
        chk("B.map",   b_map,         mb.map);
        chk("B.mv",    64'(b_mv),     64'(mb.mv));
        chk("B.pc",    64'(b_pc),     64'(mb.pc));
        chk("B.busy",  64'(b_busy),   64'(mb.ph != 2'd0));
        chk("B.dup",   64'(b_dup),    64'(mb.dup));
        chk("B.tmo",   64'(b_tmo),    64'(mb.tmo));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            ma = mdl_rst();
            mb = mdl_rst();
        end else begin
            ma = step(ma, 64, board_valid, king_sq, attacked, attacked_valid, map_ready);
            mb = step(mb, 4,  board_valid, king_sq, attacked, attacked_valid, map_ready);
        end
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        board_valid    = 1'b0;
        king_sq        = 6'd0;
        attacked       = 64'd0;
        attacked_valid = 64'd0;
        map_ready      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    logic [63:0] all_ones;
    logic [63:0] pattern;
    logic [63:0] mask;

    initial begin
        all_ones = {64{1'b1}};
        ma = mdl_rst();
        mb = mdl_rst();
        idle_inputs();
        reset = 1'b1;
        cycle();
        do_reset();
        chk("rst_map",  a_map, 64'd0);
        chk("rst_mv",   64'(a_mv), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_errs", 64'({a_dup, a_str, a_tmo, a_ovr}), 64'd0);

        // All squares in one cycle, king on square 7
        board_valid = 1'b1; king_sq = 6'd7;
        cycle();
        board_valid = 1'b0; attacked_valid = all_ones; attacked = 64'h81;
        cycle();
        chk("t1_mv",  64'(a_mv), 64'd1);
        chk("t1_map", a_map, 64'h81);
        chk("t1_ic",  64'(a_ic), 64'd1);
        chk("t1_pc",  64'(a_pc), 64'd2);
        attacked_valid = 64'd0; attacked = 64'd0; map_ready = 1'b1;
        cycle();
        chk("t1_mv_drop", 64'(a_mv), 64'd0);
        chk("t1_idle",    64'(a_busy), 64'd0);

        // Eight byte-groups over eight cycles
        do_reset();
        board_valid = 1'b1; king_sq = 6'd0;
        cycle();
        board_valid = 1'b0; attacked = all_ones;
        for (int k = 0; k < 8; k++) begin
            attacked_valid = 64'hFF << (8 * k);
            if (k == 7) attacked_valid = 64'hFF00_0000_0000_0000;
            chk("t2_not_yet", 64'(a_mv), 64'd0);
            cycle();
        end
        chk("t2_mv",   64'(a_mv), 64'd1);
        chk("t2_map",  a_map, all_ones);
        chk("t2_pc",   64'(a_pc), 64'd64);
        chk("t2_errs", 64'({a_dup, a_str, a_tmo, a_ovr}), 64'd0);

        // Duplicate on square 5, second value wins
        do_reset();
        board_valid = 1'b1; king_sq = 6'd5;
        cycle();
        board_valid = 1'b0; attacked_valid = 64'd1 << 5; attacked = 64'd1 << 5;
        cycle();
        attacked = 64'd0;
        cycle();
        chk("t3_dup", 64'(a_dup), 64'd1);
        attacked_valid = ~(64'd1 << 5);
        cycle();
        chk("t3_mv",   64'(a_mv), 64'd1);
        chk("t3_map5", 64'(a_map[5]), 64'd0);
        chk("t3_ic",   64'(a_ic), 64'd0);

        // Timeout on the TIMEOUT=4 instance
        do_reset();
        board_valid = 1'b1;
        cycle();
        board_valid = 1'b0; attacked_valid = 64'd1;
        cycle();
        attacked_valid = 64'd0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("t4_busy_mid", 64'(b_busy), 64'd1);
        end
        cycle();
        chk("t4_tmo",  64'(b_tmo), 64'd1);
        chk("t4_busy", 64'(b_busy), 64'd0);
        chk("t4_mv",   64'(b_mv), 64'd0);
        chk("t4_a_ok", 64'(a_tmo), 64'd0);

        // HOLD stall with overrun, then handshake plus new board
        do_reset();
        pattern = {$urandom, $urandom};
        board_valid = 1'b1; king_sq = 6'd33;
        cycle();
        board_valid = 1'b0; attacked_valid = all_ones; attacked = pattern;
        cycle();
        attacked_valid = 64'd0;
        for (int k = 0; k < 3; k++) begin
            board_valid = (k == 1);
            cycle();
            chk("t5_map_stable", a_map, pattern);
            chk("t5_mv_stable",  64'(a_mv), 64'd1);
        end
        board_valid = 1'b0;
        chk("t5_ovr", 64'(a_ovr), 64'd1);
        chk("t5_pc",  64'(a_pc), 64'($countones(pattern)));
        map_ready = 1'b1; board_valid = 1'b1;
        cycle();
        map_ready = 1'b0; board_valid = 1'b0;
        chk("t5_busy", 64'(a_busy), 64'd1);
        chk("t5_mv",   64'(a_mv), 64'd0);
        chk("t5_map",  a_map, 64'd0);

        // Stray valid in IDLE, then reset mid-collection
        do_reset();
        attacked_valid = 64'd1 << 10; attacked = all_ones;
        cycle();
        chk("t6_stray", 64'(a_str), 64'd1);
        chk("t6_map",   a_map, 64'd0);
        chk("t6_busy",  64'(a_busy), 64'd0);
        attacked_valid = 64'd0;
        board_valid = 1'b1;
        cycle();
        board_valid = 1'b0; attacked_valid = 64'h0000_FFFF; attacked = 64'h0000_00F0;
        cycle();
        chk("t6_partial", a_map, 64'h0000_00F0);
        reset = 1'b1; attacked_valid = all_ones;
        cycle();
        reset = 1'b0;
        chk("t6_rst_map",  a_map, 64'd0);
        chk("t6_rst_busy", 64'(a_busy), 64'd0);
        chk("t6_rst_errs", 64'({a_dup, a_str, a_tmo, a_ovr, a_mv, a_ic}), 64'd0);
        chk("t6_rst_pc",   64'(a_pc), 64'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom % 500 == 0);
            board_valid = ($urandom % 12 == 0);
            king_sq     = 6'($urandom);
            attacked    = {$urandom, $urandom};
            mask        = {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom % 3 == 0)       attacked_valid = 64'd0;
            else if ($urandom % 10 == 0) attacked_valid = all_ones;
            else                         attacked_valid = mask;
            map_ready   = $urandom % 2;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
